// File: rtl/cbi_axil_regif_if.sv
// AXI4-Lite channel bundle for cbi_axil_regif.
//   slave  modport: seen by the register front-end (AW/W/AR/B-ready in, responses out)
//   master modport: seen by the bus master driving the front-end
// Parameters: DATA_W (data width, 32 or 64), ADDR_W (address width).
interface cbi_axil_regif_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/cbi_axil_regif.sv
// AXI4-Lite slave front-end converting bus transactions into a simple
// register bus for CBI980-family cores.
// Ports:
//   aclk, arstn          clock; asynchronous active-low reset (sync release)
//   axi                  AXI4-Lite slave channels (cbi_axil_regif_if.slave)
//   reg_wr_addr/data/strb, reg_wr_en   single-cycle register write
//   reg_wr_err           core rejects the write (sampled with reg_wr_en)
//   reg_rd_addr, reg_rd_en             level read request
//   reg_rd_data, reg_rd_valid          read return from the core
module cbi_axil_regif #(
  parameter int DATA_W        = 32,
  parameter int ADDR_W        = 32,
  parameter int REG_AW        = 3,
  parameter int ALLOW_PARTIAL = 1,
  parameter int RD_TIMEOUT    = 15
) (
  input  logic                aclk,
  input  logic                arstn,
  cbi_axil_regif_if.slave     axi,
  output logic [REG_AW-1:0]   reg_wr_addr,
  output logic [DATA_W-1:0]   reg_wr_data,
  output logic [DATA_W/8-1:0] reg_wr_strb,
  output logic                reg_wr_en,
  input  logic                reg_wr_err,
  output logic [REG_AW-1:0]   reg_rd_addr,
  output logic                reg_rd_en,
  input  logic [DATA_W-1:0]   reg_rd_data,
  input  logic                reg_rd_valid
);
  localparam int STRB_W = DATA_W / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_HI = LSB + REG_AW;
  localparam bit PARTIAL_OK = (ALLOW_PARTIAL != 0);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_RESP} rstate_t;

  // Reset synchroniser: assert asynchronously, release after two aclk edges.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  // ---------------- write path ----------------
  wstate_t             wstate, wstate_nx;
  logic                aw_full, w_full, aw_decerr;
  logic [REG_AW-1:0]   aw_idx;
  logic [DATA_W-1:0]   w_data;
  logic [STRB_W-1:0]   w_strb;
  logic [1:0]          bresp_q, wr_resp;
  logic                aw_hs, w_hs, strb_ok;

  assign axi.awready = rst_n & ~aw_full & (wstate == W_IDLE);
  assign axi.wready  = rst_n & ~w_full  & (wstate == W_IDLE);
  assign axi.bvalid  = (wstate == W_RESP);
  assign axi.bresp   = bresp_q;
  assign aw_hs       = axi.awvalid & axi.awready;
  assign w_hs        = axi.wvalid  & axi.wready;
  assign strb_ok     = PARTIAL_OK | (&w_strb);

  assign reg_wr_addr = aw_idx;
  assign reg_wr_data = w_data;
  assign reg_wr_strb = w_strb;

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) wstate <= W_IDLE;
    else        wstate <= wstate_nx;
  end

  always_comb begin
    wstate_nx = wstate;
    reg_wr_en = 1'b0;
    wr_resp   = RESP_OKAY;
    unique case (wstate)
      // Incoming handshakes count as already held so the issue cycle
      // directly follows the last of the AW/W handshakes.
      W_IDLE:  if ((aw_full | aw_hs) & (w_full | w_hs)) wstate_nx = W_ISSUE;
      W_ISSUE: begin
        reg_wr_en = ~aw_decerr & strb_ok;
        if (aw_decerr)                   wr_resp = RESP_DECERR;
        else if (!strb_ok || reg_wr_err) wr_resp = RESP_SLVERR;
        wstate_nx = W_RESP;
      end
      W_RESP:  if (axi.bready) wstate_nx = W_IDLE;
      default: wstate_nx = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      aw_full   <= 1'b0;
      w_full    <= 1'b0;
      aw_decerr <= 1'b0;
      aw_idx    <= '0;
      w_data    <= '0;
      w_strb    <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      if (aw_hs) begin
        aw_full   <= 1'b1;
        aw_idx    <= axi.awaddr[IDX_HI-1:LSB];
        aw_decerr <= |axi.awaddr[ADDR_W-1:IDX_HI];
      end else if (wstate == W_RESP && axi.bready) begin
        aw_full <= 1'b0;
      end
      if (w_hs) begin
        w_full <= 1'b1;
        w_data <= axi.wdata;
        w_strb <= axi.wstrb;
      end else if (wstate == W_RESP && axi.bready) begin
        w_full <= 1'b0;
      end
      if (wstate == W_ISSUE) bresp_q <= wr_resp;
    end
  end

  // ---------------- read path ----------------
  rstate_t             rstate, rstate_nx;
  logic [REG_AW-1:0]   rd_idx;
  logic [7:0]          rd_cnt;
  logic [DATA_W-1:0]   rdata_q;
  logic [1:0]          rresp_q;
  logic                ar_hs, rd_decerr, rd_timeout;

  assign axi.arready = rst_n & (rstate == R_IDLE);
  assign axi.rvalid  = (rstate == R_RESP);
  assign axi.rdata   = rdata_q;
  assign axi.rresp   = rresp_q;
  assign ar_hs       = axi.arvalid & axi.arready;
  assign rd_decerr   = |axi.araddr[ADDR_W-1:IDX_HI];
  // Counter is 0 in the first request cycle, so the request lasts RD_TIMEOUT cycles.
  assign rd_timeout  = (rd_cnt == 8'(RD_TIMEOUT - 1));
  assign reg_rd_en   = (rstate == R_ISSUE);
  assign reg_rd_addr = rd_idx;

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) rstate <= R_IDLE;
    else        rstate <= rstate_nx;
  end

  always_comb begin
    rstate_nx = rstate;
    unique case (rstate)
      R_IDLE:  if (ar_hs) rstate_nx = rd_decerr ? R_RESP : R_ISSUE;
      R_ISSUE: if (reg_rd_valid || rd_timeout) rstate_nx = R_RESP;
      R_RESP:  if (axi.rready) rstate_nx = R_IDLE;
      default: rstate_nx = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      rd_idx  <= '0;
      rd_cnt  <= '0;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else begin
      if (ar_hs) begin
        rd_idx <= axi.araddr[IDX_HI-1:LSB];
        rd_cnt <= '0;
        if (rd_decerr) begin
          rdata_q <= '0;
          rresp_q <= RESP_DECERR;
        end
      end
      if (rstate == R_ISSUE) begin
        rd_cnt <= rd_cnt + 8'd1;
        if (reg_rd_valid) begin
          rdata_q <= reg_rd_data;
          rresp_q <= RESP_OKAY;
        end else if (rd_timeout) begin
          rdata_q <= '0;
          rresp_q <= RESP_SLVERR;
        end
      end
    end
  end

  // Byte-offset address bits carry no meaning for a register index.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{axi.awaddr[LSB-1:0], axi.araddr[LSB-1:0]};
endmodule

// File: tb/tb_cbi_axil_regif.sv
module tb_cbi_axil_regif;
  logic aclk = 1'b0;
  logic arstn = 1'b0;
  always #5 aclk = ~aclk;

  int n_assert = 0;
  int n_fail   = 0;
  int wr_pulses0 = 0;
  int wr_pulses1 = 0;

  cbi_axil_regif_if #(.DATA_W(32), .ADDR_W(32)) m0 ();
  cbi_axil_regif_if #(.DATA_W(32), .ADDR_W(32)) m1 ();

  logic [2:0]  wr_addr0, rd_addr0, wr_addr1, rd_addr1;
  logic [31:0] wr_data0, wr_data1, rd_data;
  logic [3:0]  wr_strb0, wr_strb1;
  logic        wr_en0, wr_en1, rd_en0, rd_en1, wr_err, rd_valid;

  cbi_axil_regif #(.DATA_W(32), .ADDR_W(32), .REG_AW(3), .ALLOW_PARTIAL(1), .RD_TIMEOUT(15)) u0 (
    .aclk(aclk), .arstn(arstn), .axi(m0),
    .reg_wr_addr(wr_addr0), .reg_wr_data(wr_data0), .reg_wr_strb(wr_strb0),
    .reg_wr_en(wr_en0), .reg_wr_err(wr_err),
    .reg_rd_addr(rd_addr0), .reg_rd_en(rd_en0),
    .reg_rd_data(rd_data), .reg_rd_valid(rd_valid)
  );

  // Second instance rejects partial strobes; it sees the same AXI stimulus.
  cbi_axil_regif #(.DATA_W(32), .ADDR_W(32), .REG_AW(3), .ALLOW_PARTIAL(0), .RD_TIMEOUT(15)) u1 (
    .aclk(aclk), .arstn(arstn), .axi(m1),
    .reg_wr_addr(wr_addr1), .reg_wr_data(wr_data1), .reg_wr_strb(wr_strb1),
    .reg_wr_en(wr_en1), .reg_wr_err(1'b0),
    .reg_rd_addr(rd_addr1), .reg_rd_en(rd_en1),
    .reg_rd_data(32'h0), .reg_rd_valid(1'b0)
  );

  assign m1.awaddr  = m0.awaddr;
  assign m1.awvalid = m0.awvalid;
  assign m1.wdata   = m0.wdata;
  assign m1.wstrb   = m0.wstrb;
  assign m1.wvalid  = m0.wvalid;
  assign m1.bready  = m0.bready;
  assign m1.araddr  = m0.araddr;
  assign m1.arvalid = m0.arvalid;
  assign m1.rready  = m0.rready;

  always @(negedge aclk) begin
    if (wr_en0) wr_pulses0++;
    if (wr_en1) wr_pulses1++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge aclk);
  endtask

  // AW and W presented together; returns at the issue cycle.
  task automatic wr_issue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    m0.awaddr = a; m0.awvalid = 1'b1;
    m0.wdata  = d; m0.wstrb   = s; m0.wvalid = 1'b1;
    step();
    m0.awvalid = 1'b0; m0.wvalid = 1'b0;
  endtask

  task automatic b_ack();
    m0.bready = 1'b1; step(); m0.bready = 1'b0;
  endtask

  task automatic r_ack();
    m0.rready = 1'b1; step(); m0.rready = 1'b0;
  endtask

  int p0, p1, n;
  bit got;

  initial begin
    m0.awaddr = '0; m0.awvalid = 1'b0; m0.wdata = '0; m0.wstrb = '0; m0.wvalid = 1'b0;
    m0.bready = 1'b0; m0.araddr = '0; m0.arvalid = 1'b0; m0.rready = 1'b0;
    wr_err = 1'b0; rd_valid = 1'b0; rd_data = '0;

    // reset state and synchronised release
    repeat (2) step();
    chk("rst_ctrl", {m0.awready, m0.wready, m0.bvalid, m0.arready, m0.rvalid, wr_en0, rd_en0}, 7'b0);
    chk("rst_rdata", m0.rdata, 32'h0);
    chk("rst_wrbus", {wr_data0, wr_strb0, wr_addr0, rd_addr0, m0.bresp, m0.rresp}, 46'h0);
    arstn = 1'b1;
    step();
    chk("sync_1clk", {m0.awready, m0.arready}, 2'b00);
    step();
    chk("sync_2clk", {m0.awready, m0.wready, m0.arready}, 3'b111);

    // T1: AW at c0, W at c3
    p0 = wr_pulses0;
    m0.awaddr = 32'h08; m0.awvalid = 1'b1;
    step(); m0.awvalid = 1'b0;
    chk("t1_c1", {wr_en0, m0.awready, m0.wready}, 3'b001);
    step(); step();
    m0.wdata = 32'hDEADBEEF; m0.wstrb = 4'hF; m0.wvalid = 1'b1;
    step(); m0.wvalid = 1'b0;
    chk("t1_wr_en", {wr_en0, wr_addr0, wr_strb0}, {1'b1, 3'd2, 4'hF});
    chk("t1_wr_data", wr_data0, 32'hDEADBEEF);
    chk("t1_no_b_yet", m0.bvalid, 1'b0);
    step();
    chk("t1_bvalid", {m0.bvalid, m0.bresp}, 3'b100);
    step();
    chk("t1_bhold", {m0.bvalid, m0.bresp, m0.awready, m0.wready}, 5'b10000);
    b_ack();
    chk("t1_bdone", {m0.bvalid, m0.awready, m0.wready}, 3'b011);
    chk("t1_pulses", wr_pulses0 - p0, 1);

    // T2: W before AW, bready low for 5 cycles
    p0 = wr_pulses0;
    m0.wdata = 32'hA5A50001; m0.wstrb = 4'hF; m0.wvalid = 1'b1;
    step(); m0.wvalid = 1'b0;
    chk("t2_w_held", {m0.awready, m0.wready}, 2'b10);
    m0.awaddr = 32'h1C; m0.awvalid = 1'b1;
    step(); m0.awvalid = 1'b0;
    chk("t2_wr_en", {wr_en0, wr_addr0}, {1'b1, 3'd7});
    chk("t2_wr_data", wr_data0, 32'hA5A50001);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("t2_bstall", {m0.bvalid, m0.bresp, m0.awready, m0.wready}, 5'b10000);
      step();
    end
    b_ack();
    chk("t2_bdone", {m0.bvalid, m0.awready, m0.wready}, 3'b011);
    chk("t2_pulses", wr_pulses0 - p0, 1);

    // T3: same-cycle AW+W with bready already high
    m0.bready = 1'b1;
    wr_issue(32'h04, 32'h11, 4'hF);
    chk("t3_wr_en", {wr_en0, wr_addr0}, {1'b1, 3'd1});
    step();
    chk("t3_b", {m0.bvalid, m0.bresp, m0.awready}, 4'b1000);
    step();
    chk("t3_idle", {m0.bvalid, m0.awready, m0.wready}, 3'b011);
    m0.bready = 1'b0;

    // T4: partial strobe on both instances
    p1 = wr_pulses1;
    wr_issue(32'h14, 32'h0000BEEF, 4'h3);
    chk("t4_en_partial1", {wr_en0, wr_strb0}, {1'b1, 4'h3});
    chk("t4_en_partial0", wr_en1, 1'b0);
    step();
    chk("t4_resp_partial1", {m0.bvalid, m0.bresp}, 3'b100);
    chk("t4_resp_partial0", {m1.bvalid, m1.bresp}, 3'b110);
    b_ack();
    chk("t4_pulses_partial0", wr_pulses1 - p1, 0);

    // T5: core rejects the write
    wr_issue(32'h10, 32'h55, 4'hF);
    chk("t5_wr_en", wr_en0, 1'b1);
    wr_err = 1'b1;
    step(); wr_err = 1'b0;
    chk("t5_resp", {m0.bvalid, m0.bresp}, 3'b110);
    b_ack();

    // T6: write decode error
    p0 = wr_pulses0;
    wr_issue(32'h100, 32'h77, 4'hF);
    chk("t6_no_en", wr_en0, 1'b0);
    step();
    chk("t6_resp", {m0.bvalid, m0.bresp}, 3'b111);
    b_ack();
    chk("t6_pulses", wr_pulses0 - p0, 0);

    // R1: normal read, data after 3 request cycles
    chk("r1_arready", m0.arready, 1'b1);
    m0.araddr = 32'h0C; m0.arvalid = 1'b1;
    step(); m0.arvalid = 1'b0;
    chk("r1_en", {rd_en0, rd_addr0, m0.arready}, {1'b1, 3'd3, 1'b0});
    step(); step();
    rd_valid = 1'b1; rd_data = 32'h12345678;
    step(); rd_valid = 1'b0;
    chk("r1_resp", {m0.rvalid, m0.rresp, rd_en0}, 4'b1000);
    chk("r1_rdata", m0.rdata, 32'h12345678);
    rd_valid = 1'b1; rd_data = 32'hFFFFFFFF;
    step(); rd_valid = 1'b0;
    chk("r1_ignore_late", {m0.rvalid, m0.rdata}, {1'b1, 32'h12345678});
    r_ack();
    chk("r1_done", {m0.rvalid, m0.arready}, 2'b01);
    chk("r1_keep", m0.rdata, 32'h12345678);

    // R2: read decode error
    m0.araddr = 32'h20; m0.arvalid = 1'b1;
    step(); m0.arvalid = 1'b0;
    chk("r2_resp", {m0.rvalid, m0.rresp, rd_en0}, 4'b1110);
    chk("r2_rdata", m0.rdata, 32'h0);
    r_ack();

    // R3: silent core, timeout
    m0.araddr = 32'h04; m0.arvalid = 1'b1;
    n = 0; got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(); m0.arvalid = 1'b0;
      if (m0.rvalid) begin got = 1'b1; break; end
      if (rd_en0) n++;
    end
    chk("r3_seen", got, 1'b1);
    chk("r3_en_cycles", n, 15);
    chk("r3_resp", {m0.rresp, m0.rdata}, {2'b10, 32'h0});
    r_ack();

    // R4: valid in the timeout cycle wins
    m0.araddr = 32'h18; m0.arvalid = 1'b1;
    n = 0; got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(); m0.arvalid = 1'b0; rd_valid = 1'b0;
      if (m0.rvalid) begin got = 1'b1; break; end
      if (rd_en0) begin
        n++;
        if (n == 15) begin rd_valid = 1'b1; rd_data = 32'hCAFEF00D; end
      end
    end
    rd_valid = 1'b0;
    chk("r4_seen", got, 1'b1);
    chk("r4_en_cycles", n, 15);
    chk("r4_resp", {m0.rresp, m0.rdata}, {2'b00, 32'hCAFEF00D});
    r_ack();

    // Reset during W_RESP and R_ISSUE
    wr_issue(32'h08, 32'h99, 4'hF);
    m0.araddr = 32'h0C; m0.arvalid = 1'b1;
    step(); m0.arvalid = 1'b0;
    chk("rs_pre", {m0.bvalid, rd_en0}, 2'b11);
    arstn = 1'b0;
    #1;
    chk("rs_async_ctrl", {m0.bvalid, m0.rvalid, m0.awready, m0.wready, m0.arready, wr_en0, rd_en0}, 7'b0);
    chk("rs_async_data", {m0.rdata, m0.bresp, m0.rresp}, 36'h0);
    chk("rs_async_bus", {wr_data0, wr_addr0, rd_addr0}, 38'h0);
    m0.bready = 1'b1; m0.rready = 1'b1;
    step(); arstn = 1'b1;
    step(); step();
    chk("rs_release", {m0.awready, m0.wready, m0.arready, m0.bvalid, m0.rvalid}, 5'b11100);
    step();
    chk("rs_no_stale", {m0.bvalid, m0.rvalid}, 2'b00);
    m0.bready = 1'b0; m0.rready = 1'b0;

    wr_issue(32'h0C, 32'h600D, 4'hF);
    chk("rs_wr_en", {wr_en0, wr_addr0}, {1'b1, 3'd3});
    step();
    chk("rs_wr_b", {m0.bvalid, m0.bresp}, 3'b100);
    b_ack();
    m0.araddr = 32'h08; m0.arvalid = 1'b1;
    step(); m0.arvalid = 1'b0;
    chk("rs_rd_en", {rd_en0, rd_addr0}, {1'b1, 3'd2});
    rd_valid = 1'b1; rd_data = 32'h0BADF00D;
    step(); rd_valid = 1'b0;
    chk("rs_rd_resp", {m0.rvalid, m0.rresp, m0.rdata}, {1'b1, 2'b00, 32'h0BADF00D});
    r_ack();
    chk("rs_rd_done", {m0.rvalid, m0.arready}, 2'b01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
